// File: rtl/stream_avg_accum.sv
// -----------------------------------------------------------------------------
// stream_avg_accum
//
// Streaming window averager. Accepts one unsigned sample per valid/ready
// transfer and accumulates 2^WINDOW_LOG2 samples with a single adder. The
// transfer that completes a window shifts the full sum right by sa (sampled on
// that same transfer) and presents the low DATAWIDTH bits on a valid/ready
// output. The result is held until the consumer takes it; no samples are
// accepted while a result is pending.
//
// Optional feature (compile-time macro STREAM_AVG_ROUND_EN):
//   defined   - round half up: add 2^(sa-1) before the shift when
//               1 <= sa < ACCWIDTH, at ACCWIDTH+1 bits so the add cannot wrap.
//   undefined - plain truncating (floor) shift.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; discards partial window/result
//   in_data    unsigned sample
//   in_valid   sample present
//   in_ready   block accepts a sample this cycle (registered)
//   sa         right-shift amount applied to the window sum
//   out_data   averaged result (registered)
//   out_valid  result present (registered)
//   out_ready  consumer takes the result
//   win_count  samples accepted in the current window (registered)
// -----------------------------------------------------------------------------
module stream_avg_accum #(
    parameter int unsigned DATAWIDTH   = 16,
    parameter int unsigned WINDOW_LOG2 = 3,
    parameter int unsigned ACCWIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATAWIDTH-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             sa,
    output logic [DATAWIDTH-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WINDOW_LOG2-1:0] win_count
);

    // One spare bit so the rounding increment never wraps the sum.
    localparam int unsigned EXTW = ACCWIDTH + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [ACCWIDTH-1:0]    acc;
    logic [ACCWIDTH-1:0]    acc_nxt;
    logic [WINDOW_LOG2-1:0] win_count_nxt;
    logic [DATAWIDTH-1:0]   out_data_nxt;
    logic                   out_valid_nxt;
    logic                   in_ready_nxt;

    logic                   in_xfer_c;
    logic                   last_c;
    logic                   sa_oor_c;
    logic [ACCWIDTH-1:0]    sum_c;
    logic [EXTW-1:0]        sum_ext_c;
    logic [EXTW-1:0]        rounded_c;
    logic [EXTW-1:0]        shifted_c;
    logic [DATAWIDTH-1:0]   result_c;

    // Handshake and window-boundary decode.
    assign in_xfer_c = in_valid & in_ready;
    assign last_c    = (win_count == {WINDOW_LOG2{1'b1}});

    // Running sum including the sample being transferred this cycle.
    assign sum_c     = acc + ACCWIDTH'(in_data);
    assign sum_ext_c = EXTW'(sum_c);

    // Shift amounts at or beyond the accumulator width flush to zero.
    assign sa_oor_c  = (32'(sa) >= ACCWIDTH);

    // Optional round-half-up bias ahead of the shift.
    always_comb begin
        rounded_c = sum_ext_c;
`ifdef STREAM_AVG_ROUND_EN
        if ((sa != 8'd0) && !sa_oor_c) begin
            rounded_c = sum_ext_c + (EXTW'(1) << (sa - 8'd1));
        end
`endif
    end

    // Scale and truncate to the output width (low bits kept).
    always_comb begin
        shifted_c = '0;
        if (!sa_oor_c) begin
            shifted_c = rounded_c >> sa;
        end
        result_c = shifted_c[DATAWIDTH-1:0];
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            win_count <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            win_count <= win_count_nxt;
            out_data  <= out_data_nxt;
            out_valid <= out_valid_nxt;
            in_ready  <= in_ready_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        win_count_nxt = win_count;
        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;
        in_ready_nxt  = in_ready;

        case (state)
            ACCUM: begin
                if (in_xfer_c) begin
                    if (last_c) begin
                        // Completing sample goes straight into the shifter.
                        out_data_nxt  = result_c;
                        acc_nxt       = '0;
                        win_count_nxt = '0;
                        out_valid_nxt = 1'b1;
                        in_ready_nxt  = 1'b0;
                        state_nxt     = HOLD;
                    end else begin
                        acc_nxt       = sum_c;
                        win_count_nxt = win_count + WINDOW_LOG2'(1);
                    end
                end
            end

            HOLD: begin
                // Result stays put until the consumer handshakes.
                if (out_valid && out_ready) begin
                    out_valid_nxt = 1'b0;
                    in_ready_nxt  = 1'b1;
                    state_nxt     = ACCUM;
                end
            end

            default: begin
                state_nxt     = ACCUM;
                acc_nxt       = '0;
                win_count_nxt = '0;
                out_valid_nxt = 1'b0;
                in_ready_nxt  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_stream_avg_accum.sv
// -----------------------------------------------------------------------------
// tb_stream_avg_accum
//
// Self-checking bench for stream_avg_accum. A table of windows (sample pattern,
// shift amount, expected result for floor and rounding builds) is applied in a
// loop; expected results go into a scoreboard queue when the completing sample
// is driven and are popped when the DUT raises out_valid. Hand-written
// sequences cover asynchronous reset mid-window and while holding a result.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_stream_avg_accum;

    localparam int unsigned DW = 16;
    localparam int unsigned WL = 3;
    localparam int unsigned AW = 32;
    localparam int          NSAMP = 8;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    sa;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [WL-1:0] win_count;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic [15:0] base;
        logic [15:0] step;
        logic [7:0]  sa;
        logic [15:0] exp_f;
        logic [15:0] exp_r;
        int          gapmax;
        int          hold;
    } vec_t;

    vec_t vecs[12];

    stream_avg_accum #(
        .DATAWIDTH  (DW),
        .WINDOW_LOG2(WL),
        .ACCWIDTH   (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sa       (sa),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .win_count(win_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one window; leaves the DUT in HOLD when take == 0.
    task automatic run_window(input logic [15:0] base, input logic [15:0] step,
                              input logic [7:0] sa_last, input logic [15:0] expv,
                              input int gapmax, input int hold, input bit take);
        int            g;
        int            k;
        logic [DW-1:0] held;
        for (int i = 0; i < NSAMP; i++) begin
            g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            in_valid = 1'b0;
            for (int j = 0; j < g; j++) begin
                in_data = 16'($urandom);
                sa      = 8'($urandom);
                @(negedge clk);
            end
            check("in_ready_accum", 32'(in_ready), 32'd1);
            check("win_count_step", 32'(win_count), 32'(i));
            in_valid = 1'b1;
            in_data  = 16'(32'(base) + i * 32'(step));
            sa       = (i == NSAMP - 1) ? sa_last : 8'($urandom);
            if (i == NSAMP - 1) exp_q.push_back(expv);
            @(negedge clk);
        end
        in_valid = 1'b0;
        sa       = 8'($urandom);
        if (hold > 0 || !take) out_ready = 1'b0;

        k = 0;
        while (!out_valid && k < 4) begin
            @(negedge clk);
            k++;
        end
        check("out_valid_latency", 32'(k), 32'd0);
        check("in_ready_hold", 32'(in_ready), 32'd0);
        check("win_count_hold", 32'(win_count), 32'd0);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_empty: got result 0x%0h want none pending", out_data);
        end else begin
            check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        held = out_data;

        // Backpressure: inputs wiggle, nothing may move.
        for (int j = 0; j < hold; j++) begin
            in_valid = 1'($urandom);
            in_data  = 16'($urandom);
            sa       = 8'($urandom);
            @(negedge clk);
            check("hold_out_data", 32'(out_data), 32'(held));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;

        if (take) begin
            out_ready = 1'b1;
            @(negedge clk);
            check("after_take_out_valid", 32'(out_valid), 32'd0);
            check("after_take_in_ready", 32'(in_ready), 32'd1);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_win_count"}, 32'(win_count), 32'd0);
    endtask

    initial begin
        //            base      step    sa     floor       round     gap hold
        vecs[0]  = '{16'd1,    16'd1,   8'd3,  16'd4,      16'd5,      0, 0};
        vecs[1]  = '{16'hFFFF, 16'd0,   8'd3,  16'hFFFF,   16'hFFFF,   0, 10};
        vecs[2]  = '{16'hFFFF, 16'd0,   8'd0,  16'hFFF8,   16'hFFF8,   1, 0};
        vecs[3]  = '{16'd100,  16'd100, 8'd3,  16'd450,    16'd450,    3, 0};
        vecs[4]  = '{16'd10,   16'd0,   8'd2,  16'd20,     16'd20,     2, 3};
        vecs[5]  = '{16'd2,    16'd0,   8'd3,  16'd2,      16'd2,      0, 0};
        vecs[6]  = '{16'd5,    16'd3,   8'd40, 16'd0,      16'd0,      1, 0};
        vecs[7]  = '{16'd5,    16'd3,   8'd32, 16'd0,      16'd0,      0, 2};
        vecs[8]  = '{16'd5,    16'd3,   8'd31, 16'd0,      16'd0,      0, 0};
        vecs[9]  = '{16'd7,    16'd0,   8'd1,  16'd28,     16'd28,     2, 0};
        vecs[10] = '{16'd3,    16'd0,   8'd4,  16'd1,      16'd2,      0, 1};
        vecs[11] = '{16'd1000, 16'd1,   8'd5,  16'd250,    16'd251,    3, 0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        sa        = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("post_reset");

        for (int v = 0; v < 12; v++) begin
`ifdef STREAM_AVG_ROUND_EN
            run_window(vecs[v].base, vecs[v].step, vecs[v].sa, vecs[v].exp_r,
                       vecs[v].gapmax, vecs[v].hold, 1'b1);
`else
            run_window(vecs[v].base, vecs[v].step, vecs[v].sa, vecs[v].exp_f,
                       vecs[v].gapmax, vecs[v].hold, 1'b1);
`endif
        end

        // Asynchronous reset after five samples of a window.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'd7;
            sa       = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("partial_win_count", 32'(win_count), 32'd5);
        #2 rst = 1'b1;
        #1 check_reset_vals("async_partial");
        @(negedge clk);
        rst = 1'b0;
        run_window(16'd2, 16'd0, 8'd3, 16'd2, 0, 0, 1'b1);

        // Asynchronous reset while a result is held.
        run_window(16'd9, 16'd0, 8'd3, 16'd9, 0, 0, 1'b0);
        #2 rst = 1'b1;
        #1 check_reset_vals("async_hold");
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_reset_vals("after_hold_reset");
        run_window(16'd2, 16'd0, 8'd3, 16'd2, 1, 0, 1'b1);

        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d pending want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stream_avg_accum.md
Name:
stream_avg_accum

Overview:
- Sequential streaming counterpart of the parallel 8-input averaging datapath.
- Collects samples one at a time over a valid/ready input, accumulates a window of 2^WINDOW_LOG2 samples, shifts the sum right by the runtime amount sa, and presents the result on a valid/ready output.
- Sits between a sample producer and a downstream consumer, so one adder replaces the full adder tree.

Parameters:
- DATAWIDTH, 16: sample width and result width, in bits.
- WINDOW_LOG2, 3: log2 of the number of samples per window (default window is 8).
- ACCWIDTH, 32: accumulator width in bits. Must be ≥ DATAWIDTH+WINDOW_LOG2.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-high reset.
- in_data  input  DATAWIDTH  unsigned sample.
- in_valid  input  1  sample is present.
- in_ready  output  1  block accepts a sample this cycle.
- sa  input  8  unsigned right-shift amount applied to the window sum.
- out_data  output  DATAWIDTH  averaged result.
- out_valid  output  1  result is present.
- out_ready  input  1  consumer takes the result.
- win_count  output  WINDOW_LOG2  number of samples accepted in the current window.

Behaviour:
- Reset values: state=ACCUM, acc=0, win_count=0, out_data=0, out_valid=0, in_ready=1. Reset is asynchronous. It aborts any partial window or held result and discards both.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - Input transfer occurs when in_valid&in_ready on a rising edge. On a transfer: acc <= acc + zero-extended in_data, and win_count increments.
  - The transfer that completes the window (win_count == 2^WINDOW_LOG2-1) loads the full sum into the shifter, not acc.
    - out_data <= (full sum >> sa)[DATAWIDTH-1:0].
    - acc and win_count clear to 0.
    - state <= HOLD.
  - out_valid rises on the cycle after the last sample is accepted (1-cycle latency).
- sa handling:
  - sa is sampled only on the completing transfer. Changes at any other time have no effect on the result.
  - sa ≥ ACCWIDTH yields out_data=0.
- State HOLD:
  - out_valid=1 and in_ready=0. No samples are accepted and in_data is ignored.
  - out_data is stable until taken.
  - When out_valid&out_ready on a rising edge: out_valid <= 0 and state <= ACCUM.
  - in_ready returns to 1 in the cycle after the handshake. There is no bypass, so the minimum period is 2^WINDOW_LOG2+1 cycles per result.
- out_ready asserted while out_valid=0 has no effect.
- in_valid low in ACCUM holds acc and win_count unchanged. Gaps between samples are unlimited.
- Arithmetic:
  - All arithmetic is unsigned, at width ACCWIDTH.
  - Overflow cannot occur at the legal parameter values.
  - Truncation to DATAWIDTH keeps the low bits, e.g. sa=0 reports the sum modulo 2^DATAWIDTH.
- win_count wraps to 0 at window completion. It reads 0 throughout HOLD.

Optional Feature:
- Macro: STREAM_AVG_ROUND_EN.
- Defined:
  - Before the shift, add 2^(sa-1) to the sum (round half up) when 1 ≤ sa < ACCWIDTH. sa=0 adds nothing.
  - The addition is performed at ACCWIDTH+1 bits, so there is no wrap.
  - The result is still truncated to DATAWIDTH.
- Undefined: plain truncating shift (floor), as described in Behaviour.

Test Plan:
- Reset, then 8 back-to-back samples 1..8 with sa=3, out_ready=1 → sum 36; out_valid=1 one cycle after the 8th accept, with out_data=4 (5 with STREAM_AVG_ROUND_EN); in_ready=0 during that cycle; in_ready=1 the following cycle.
- 8 samples of 0xFFFF with sa=3 → out_data=0xFFFF. Same samples with sa=0 → out_data=0xFFF8 (0x7FFF8 truncated).
- Backpressure: complete a window, hold out_ready=0 for 10 cycles while toggling in_valid and in_data → out_data stable, in_ready=0, no samples absorbed. Raise out_ready → next window starts from acc=0.
- Irregular in_valid (random gaps), samples 100,200,...,800 with sa=3 → out_data=450; win_count steps 0..7 only on accepts.
- Change sa from 3 to 1 mid-window, then to 2 on the completing cycle, samples all 10 → out_data=20 (80>>2).
- Assert Rst asynchronously after 5 samples, and again while in HOLD → outputs drop to reset values immediately without waiting for a clock edge. The next 8 samples of 2 with sa=3 give out_data=2 (no stale contribution).
